// File: rtl/alu_pkg.sv
// Shared types and constants for the slice-serial 74181 ALU.
// Build with ALU_OVF_EN defined to add the signed-overflow flag.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int ALU_SLICE = 4;

  localparam logic [3:0] ALU_S_ADD  = 4'b1001;
  localparam logic [3:0] ALU_S_SUB  = 4'b0110;
  localparam logic [3:0] ALU_S_XOR  = 4'b0110;
  localparam logic [3:0] ALU_S_ZERO = 4'b0011;
  localparam logic [3:0] ALU_S_PASS = 4'b1111;

endpackage

// File: rtl/alu_if.sv
// Request/response bundle of the slice-serial ALU.
// ALU_OVF_EN adds the ovf flag to the bundle.
interface alu_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       s;
  logic             m;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             aeqb;
  logic             zero;
`ifdef ALU_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, s, m, cin, a, b,
    output out_ready,
    input  in_ready, out_valid,
    input  f, cout, aeqb, zero
`ifdef ALU_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, s, m, cin, a, b,
    input  out_ready,
    output in_ready, out_valid,
    output f, cout, aeqb, zero
`ifdef ALU_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE-bit 74181 function, active-high data.
// c_msb (carry into the top bit) exists only with ALU_OVF_EN.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = ALU_SLICE
) (
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] f,
  output logic             cout
`ifdef ALU_OVF_EN
  , output logic           c_msb
`endif
);

  localparam logic [SLICE-1:0] ONES = '1;

  logic [SLICE-1:0] x;
  logic [SLICE-1:0] y;
  logic [SLICE-1:0] lg;
  logic [SLICE:0]   sum;

  always_comb begin
    lg = '0;
    unique case (s)
      4'b0000: lg = ~a;
      4'b0001: lg = ~(a | b);
      4'b0010: lg = ~a & b;
      4'b0011: lg = '0;
      4'b0100: lg = ~(a & b);
      4'b0101: lg = ~b;
      4'b0110: lg = a ^ b;
      4'b0111: lg = a & ~b;
      4'b1000: lg = ~a | b;
      4'b1001: lg = ~(a ^ b);
      4'b1010: lg = b;
      4'b1011: lg = a & b;
      4'b1100: lg = ONES;
      4'b1101: lg = a | ~b;
      4'b1110: lg = a | b;
      4'b1111: lg = a;
    endcase
  end

  // arithmetic mode is X + Y + cin with bitwise-formed X and Y
  always_comb begin
    x = a;
    y = '0;
    unique case (s)
      4'b0000: x = a;
      4'b0001: x = a | b;
      4'b0010: x = a | ~b;
      4'b0011: begin x = '0;      y = ONES;   end
      4'b0100: begin x = a;       y = a & ~b; end
      4'b0101: begin x = a | b;   y = a & ~b; end
      4'b0110: begin x = a;       y = ~b;     end
      4'b0111: begin x = a & ~b;  y = ONES;   end
      4'b1000: begin x = a;       y = a & b;  end
      4'b1001: begin x = a;       y = b;      end
      4'b1010: begin x = a | ~b;  y = a & b;  end
      4'b1011: begin x = a & b;   y = ONES;   end
      4'b1100: begin x = a;       y = a;      end
      4'b1101: begin x = a | b;   y = a;      end
      4'b1110: begin x = a | ~b;  y = a;      end
      4'b1111: begin x = a;       y = ONES;   end
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};

  assign f    = m ? lg : sum[SLICE-1:0];
  assign cout = m ? 1'b0 : sum[SLICE];

`ifdef ALU_OVF_EN
  assign c_msb = m ? 1'b0
               : sum[SLICE-1] ^ x[SLICE-1] ^ y[SLICE-1];
`endif

endmodule

// File: rtl/alu_seq.sv
// Slice-serial 74181 ALU: one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow flag under ALU_OVF_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = ALU_SLICE
) (
  input logic clk,
  input logic rst_n,
  alu_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_t           st;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             c_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] f_q;
  logic             cout_q;
  logic             aeqb_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SLICE-1:0] sl_f;
  logic             sl_cout;
  logic [WIDTH-1:0] f_nx;

`ifdef ALU_OVF_EN
  logic sl_cmsb;
  logic ovf_q;
`endif

  alu_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .s     (s_q),
    .m     (m_q),
    .cin   (c_q),
    .a     (a_q[idx*SLICE +: SLICE]),
    .b     (b_q[idx*SLICE +: SLICE]),
    .f     (sl_f),
    .cout  (sl_cout)
`ifdef ALU_OVF_EN
    , .c_msb (sl_cmsb)
`endif
  );

  // flags are judged on the word as it will look once this slice lands
  always_comb begin
    f_nx = f_q;
    f_nx[idx*SLICE +: SLICE] = sl_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      m_q         <= 1'b0;
      c_q         <= 1'b0;
      idx         <= '0;
      f_q         <= '0;
      cout_q      <= 1'b0;
      aeqb_q      <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            s_q        <= bus.s;
            m_q        <= bus.m;
            c_q        <= bus.cin;
            idx        <= '0;
            in_ready_q <= 1'b0;
            st         <= RUN;
          end
        end
        RUN: begin
          f_q <= f_nx;
          c_q <= sl_cout;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            idx         <= '0;
            cout_q      <= sl_cout;
            aeqb_q      <= &f_nx;
            zero_q      <= (f_nx == '0);
            out_valid_q <= 1'b1;
            st          <= DONE;
`ifdef ALU_OVF_EN
            ovf_q       <= sl_cmsb ^ sl_cout;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            st          <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          st          <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.cout      = cout_q;
  assign bus.aeqb      = aeqb_q;
  assign bus.zero      = zero_q;
`ifdef ALU_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16, SLICE=4).
// Reference model evaluates the 74181 table on whole words.
module tb_alu_seq;

  localparam int W = 16;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  alu_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH (W),
    .SLICE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns {ovf, cout, f}
  function automatic logic [17:0] ref_alu(input logic [3:0] s,
                                          input logic m,
                                          input logic ci,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] x, y, lg;
    logic [16:0] sum, lo;
    x = a;
    y = 16'h0;
    lg = 16'h0;
    if (m) begin
      case (s)
        4'd0:  lg = ~a;
        4'd1:  lg = ~(a | b);
        4'd2:  lg = ~a & b;
        4'd3:  lg = 16'h0000;
        4'd4:  lg = ~(a & b);
        4'd5:  lg = ~b;
        4'd6:  lg = a ^ b;
        4'd7:  lg = a & ~b;
        4'd8:  lg = ~a | b;
        4'd9:  lg = ~(a ^ b);
        4'd10: lg = b;
        4'd11: lg = a & b;
        4'd12: lg = 16'hFFFF;
        4'd13: lg = a | ~b;
        4'd14: lg = a | b;
        default: lg = a;
      endcase
      return {2'b00, lg};
    end
    case (s)
      4'd0:  x = a;
      4'd1:  x = a | b;
      4'd2:  x = a | ~b;
      4'd3:  begin x = 16'h0;  y = 16'hFFFF; end
      4'd4:  begin x = a;      y = a & ~b; end
      4'd5:  begin x = a | b;  y = a & ~b; end
      4'd6:  begin x = a;      y = ~b; end
      4'd7:  begin x = a & ~b; y = 16'hFFFF; end
      4'd8:  begin x = a;      y = a & b; end
      4'd9:  begin x = a;      y = b; end
      4'd10: begin x = a | ~b; y = a & b; end
      4'd11: begin x = a & b;  y = 16'hFFFF; end
      4'd12: begin x = a;      y = a; end
      4'd13: begin x = a | b;  y = a; end
      4'd14: begin x = a | ~b; y = a; end
      default: begin x = a;    y = 16'hFFFF; end
    endcase
    sum = 17'(x) + 17'(y) + 17'(ci);
    lo  = 17'(x[14:0]) + 17'(y[14:0]) + 17'(ci);
    return {lo[15] ^ sum[16], sum[16], sum[15:0]};
  endfunction

  task automatic check_result(input string tag, input logic [17:0] e);
    chk({tag, ".f"}, 32'(bus.f), 32'(e[15:0]));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(e[16]));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(e[15:0] == 16'h0));
    chk({tag, ".aeqb"}, 32'(bus.aeqb), 32'(&e[15:0]));
`ifdef ALU_OVF_EN
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(e[17]));
`endif
  endtask

  // issue one op, wait for the result, check latency and value
  task automatic issue(input string tag,
                       input logic [3:0] s, input logic m,
                       input logic ci,
                       input logic [15:0] a, input logic [15:0] b);
    int lat;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.s = s; bus.m = m; bus.cin = ci;
    bus.a = a; bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(NS));
    check_result(tag, ref_alu(s, m, ci, a, b));
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".ovalid_clr"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".iready_set"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] f_hold;
    logic [3:0] rs;
    logic rm, rc;
    logic [15:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.s = '0; bus.m = 1'b0; bus.cin = 1'b0;
    bus.a = '0; bus.b = '0;
    #12;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.f", 32'(bus.f), 32'd0);
    chk("rst.flags", 32'({bus.cout, bus.aeqb, bus.zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("add", 4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FFF);
    chk("add.f_lit", 32'(bus.f), 32'h2233);
    consume("add");
    issue("sub_c1", 4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0005);
    chk("sub_c1.zero_lit", 32'(bus.zero), 32'd1);
    consume("sub_c1");
    issue("sub_c0", 4'b0110, 1'b0, 1'b0, 16'h0005, 16'h0005);
    chk("sub_c0.aeqb_lit", 32'(bus.aeqb), 32'd1);
    consume("sub_c0");
    issue("ripple", 4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    chk("ripple.cout_lit", 32'(bus.cout), 32'd1);
    consume("ripple");
    issue("sovf", 4'b1001, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    chk("sovf.f_lit", 32'(bus.f), 32'h8000);
    consume("sovf");
    issue("xor", 4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    chk("xor.f_lit", 32'(bus.f), 32'h0FF0);
    consume("xor");
    issue("lzero", 4'b0011, 1'b1, 1'b0, 16'hABCD, 16'h1234);
    consume("lzero");

    // backpressure with junk on the request side
    issue("bp", 4'b1001, 1'b0, 1'b1, 16'h4321, 16'h1111);
    f_hold = bus.f;
    for (int i = 0; i < 5; i++) begin
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("bp.ovalid", 32'(bus.out_valid), 32'd1);
      chk("bp.iready", 32'(bus.in_ready), 32'd0);
      chk("bp.f", 32'(bus.f), 32'(f_hold));
    end
    check_result("bp.end", ref_alu(4'b1001, 1'b0, 1'b1, 16'h4321, 16'h1111));
    bus.in_valid = 1'b0;
    consume("bp");

    // reset two slices into RUN
    bus.s = 4'b1001; bus.m = 1'b0; bus.cin = 1'b0;
    bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst.f", 32'(bus.f), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue("post_rst", 4'b1001, 1'b0, 1'b0, 16'h0003, 16'h0004);
    chk("post_rst.f_lit", 32'(bus.f), 32'h0007);
    consume("post_rst");

    // random ops with random consumer stall
    for (int n = 0; n < 60; n++) begin
      rs = 4'($urandom);
      rm = 1'($urandom);
      rc = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue("rnd", rs, rm, rc, ra, rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      check_result("rnd.hold", ref_alu(rs, rm, rc, ra, rb));
      consume("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
